// File: rtl/fifo_rd_streamer.sv
// Read-side drain engine: pops the async FIFO into a 2-entry buffer and streams bursts downstream.
// Optional FIFO_RD_PARITY_EN adds a per-word out_parity bit stored alongside each buffered word.
//   state | meaning
//   EMPTY | no word buffered, out_valid low
//   ONE   | head slot holds the oldest word
//   TWO   | head and tail both hold words, FIFO pops stall
`timescale 1ns/1ps
module fifo_rd_streamer #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = 8
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
`ifdef FIFO_RD_PARITY_EN
  output logic              out_parity,
`endif
  output logic [CNT_W-1:0]  pkt_cnt
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t              state;
  logic [DATA_W-1:0] tail_q;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beat_nxt;
  logic              valid_nxt;
  logic              push;
  logic              pop;
`ifdef FIFO_RD_PARITY_EN
  logic              tail_par;
  logic              in_par;

  assign in_par = ^fifo_rd_data;
`endif

  assign fifo_rd_en = !rd_rst && !fifo_empty && (state != TWO);
  assign push       = fifo_rd_en;
  assign pop        = out_valid && out_ready;

  always_comb begin
    beat_nxt = beat_cnt;
    if (pop) beat_nxt = out_last ? '0 : beat_cnt + 1'b1;
    case (state)
      EMPTY:   valid_nxt = push;
      ONE:     valid_nxt = push || !pop;
      default: valid_nxt = 1'b1;
    endcase
  end

  // out_valid/out_last are registered from the next-state view so they align with out_data
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      tail_q    <= '0;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
`ifdef FIFO_RD_PARITY_EN
      out_parity <= 1'b0;
      tail_par   <= 1'b0;
`endif
    end else begin
      out_valid <= valid_nxt;
      out_last  <= valid_nxt && (beat_nxt == LAST_BEAT);
      beat_cnt  <= beat_nxt;
      if (pop && out_last) pkt_cnt <= pkt_cnt + 1'b1;
      case (state)
        EMPTY: begin
          if (push) begin
            out_data <= fifo_rd_data;
`ifdef FIFO_RD_PARITY_EN
            out_parity <= in_par;
`endif
            state <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            out_data <= fifo_rd_data;
`ifdef FIFO_RD_PARITY_EN
            out_parity <= in_par;
`endif
          end else if (push) begin
            tail_q <= fifo_rd_data;
`ifdef FIFO_RD_PARITY_EN
            tail_par <= in_par;
`endif
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            out_data <= tail_q;
`ifdef FIFO_RD_PARITY_EN
            out_parity <= tail_par;
`endif
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Scoreboard bench for fifo_rd_streamer: queue-modelled FIFO, expected-word queue, negedge monitor.
`timescale 1ns/1ps
module tb_fifo_rd_streamer;
  localparam int DW = 16;
  localparam int BL = 8;
  localparam int CW = 2;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_en;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [CW-1:0] pkt_cnt;
`ifdef FIFO_RD_PARITY_EN
  logic          out_parity;
`endif

  fifo_rd_streamer #(.DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last),
`ifdef FIFO_RD_PARITY_EN
    .out_parity(out_parity),
`endif
    .pkt_cnt(pkt_cnt));

  always #5 rd_clk = ~rd_clk;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int  beats = 0;          // beats accepted downstream since the last reset
  int  rd_en_pulses = 0;
  int  n_checks = 0;
  int  n_errors = 0;
  bit  rd_en_seen = 0;
  bit  prev_hold = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Monitor: sampled on the falling edge, inputs and outputs are stable here.
  always @(negedge rd_clk) begin
    int occ;
    logic [DW-1:0] d;
    rd_en_seen = fifo_rd_en;
    if (fifo_rd_en) rd_en_pulses++;
    if (fifo_empty || rd_rst) chk(!fifo_rd_en, "rd_en_gate", 32'(fifo_rd_en), 0);
    if (!rd_rst) begin
      occ = exp_q.size() - fifo_q.size();
      chk(out_valid == (occ != 0) && occ <= 2, "occupancy", 32'(out_valid), 32'(occ));
      chk(pkt_cnt == CW'(beats / BL), "pkt_cnt", 32'(pkt_cnt), 32'(CW'(beats / BL)));
      if (prev_hold)
        chk(out_valid && out_data == prev_data && out_last == prev_last, "hold_stable",
            32'(out_data), 32'(prev_data));
`ifdef FIFO_RD_PARITY_EN
      if (out_valid) chk(out_parity == ^out_data, "parity", 32'(out_parity), 32'(^out_data));
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", 32'(out_data), 0);
        end else begin
          d = exp_q.pop_front();
          chk(out_data == d, "data", 32'(out_data), 32'(d));
          chk(out_last == ((beats % BL) == BL - 1), "last", 32'(out_last),
              32'((beats % BL) == BL - 1));
          beats++;
        end
      end
    end
    prev_hold = !rd_rst && out_valid && !out_ready;
    prev_data = out_data;
    prev_last = out_last;
  end

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? DW'($urandom) : fifo_q[0];
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    refresh();
  endtask

  // Apply inputs for one cycle, advance past the edge, update the FIFO model.
  task automatic step(input bit rdy, input bit rst);
    int drop;
    out_ready = rdy;
    rd_rst = rst;
    @(posedge rd_clk);
    #1;
    if (rd_en_seen) void'(fifo_q.pop_front());
    if (rst) begin
      drop = exp_q.size() - fifo_q.size();
      repeat (drop) void'(exp_q.pop_front());
      beats = 0;
    end
    refresh();
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) step(1'b1, 1'b0);
    chk(exp_q.size() == 0, name, 32'(exp_q.size()), 0);
  endtask

  initial begin
    int p0;
    logic [CW-1:0] prev_pkt;
    logic [CW-1:0] seq[$];
    logic [CW-1:0] want_seq [5];
    want_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk(!out_valid && !out_last && pkt_cnt == 0 && out_data == 0, "reset_state",
        {15'd0, out_valid, out_data}, 0);

    // three words, latency of one cycle from fifo_empty falling
    p0 = rd_en_pulses;
    out_ready = 1'b1;
    rd_rst = 1'b0;
    write_word(16'h0001); write_word(16'h0002); write_word(16'h0003);
    @(negedge rd_clk);
    chk(!out_valid && fifo_rd_en, "latency_pre", 32'(out_valid), 0);
    step(1'b1, 1'b0);
    chk(out_valid && out_data == 16'h0001, "latency_first", 32'(out_data), 1);
    drain("drain_three");
    step(1'b1, 1'b0);
    chk(rd_en_pulses - p0 == 3, "pop_count_three", 32'(rd_en_pulses - p0), 3);

    // 16 words -> two bursts
    step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) write_word(DW'($urandom));
    drain("drain_sixteen");
    chk(pkt_cnt == 2, "pkt_after_16", 32'(pkt_cnt), 2);

    // back-pressure: exactly two pops, then stall with stable head
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) write_word(DW'(16'hA0 + i));
    p0 = rd_en_pulses;
    repeat (5) step(1'b0, 1'b0);
    chk(rd_en_pulses - p0 == 2, "bp_pops", 32'(rd_en_pulses - p0), 2);
    chk(!fifo_rd_en && out_data == 16'h00A0, "bp_stall", 32'(out_data), 32'h00A0);
    drain("bp_drain");
    chk(fifo_q.size() == 0, "bp_fifo_empty", 32'(fifo_q.size()), 0);

    // reset with occupancy 2 and beat_cnt 5 after one full burst
    step(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) write_word(DW'($urandom));
    for (int i = 0; i < 100 && beats < 13; i++) step(1'b1, 1'b0);
    chk(beats == 13, "mid_beats", 32'(beats), 13);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk(out_valid && !fifo_rd_en && pkt_cnt == 1, "occ_two", 32'(fifo_rd_en), 0);
    rd_rst = 1'b1;
    @(negedge rd_clk);
    chk(!fifo_rd_en, "rd_en_in_reset", 32'(fifo_rd_en), 0);
    step(1'b0, 1'b1);
    chk(!out_valid && pkt_cnt == 0, "mid_reset_clear", {pkt_cnt, out_valid}, 0);
    chk(fifo_q.size() == 15, "no_pop_in_reset", 32'(fifo_q.size()), 15);
    drain("post_reset_drain");

    // five bursts with a 2-bit counter
    step(1'b1, 1'b1);
    for (int i = 0; i < 5 * BL; i++) write_word(DW'($urandom));
    prev_pkt = pkt_cnt;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      step(1'b1, 1'b0);
      if (pkt_cnt != prev_pkt) begin
        seq.push_back(pkt_cnt);
        prev_pkt = pkt_cnt;
      end
    end
    chk(seq.size() == 5, "pkt_seq_len", 32'(seq.size()), 5);
    for (int i = 0; i < seq.size() && i < 5; i++)
      chk(seq[i] == want_seq[i], "pkt_seq", 32'(seq[i]), 32'(want_seq[i]));

`ifdef FIFO_RD_PARITY_EN
    step(1'b0, 1'b1);
    write_word(16'h0003);
    write_word(16'h0007);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk(out_valid && out_parity == 1'b0, "parity_3", 32'(out_parity), 0);
    step(1'b1, 1'b0);
    chk(out_valid && out_parity == 1'b1, "parity_7", 32'(out_parity), 1);
    drain("parity_drain");
`endif

    // random traffic with occasional resets
    step(1'b1, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 32)
        repeat ($urandom_range(1, 3)) write_word(DW'($urandom));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
    end
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
